rst_sequencer: RTL and testbench

Parametrised reset sequencer for the KyogenRV FPGA top: it replaces the fixed two-flop reset synchroniser and the plain `reset & pll_locked` gating. It debounces PLL lock and releases N reset domains in a fixed, staggered order (e.g. SDRAM controller, then interconnect and peripherals, then CPU core). It re-enters reset on PLL lock loss or on a software request, and records the cause of the last reset for firmware to read.

---
 rtl/rst_seq_pkg.sv | 28 ++
 rtl/sync_ff.sv | 24 ++
 rtl/rst_sequencer.sv | 163 ++++++++++++++++
 tb/tb_rst_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// Imported by the sequencer top.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      HOLD,
      WAIT_LOCK,
      STAGGER,
      RUN
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_PIN  = 2'd0,
      CAUSE_LOCK = 2'd1,
      CAUSE_SW   = 2'd2
   } cause_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic int width_of(input int v);
      return (v < 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser with asynchronous active-low clear.
// Output follows d after STAGES clock edges.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk_riscv,
   input  logic clr_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clk_riscv or negedge clr_n) begin
      if (!clr_n) begin
         sr <= '0;
      end else begin
         sr <= {sr[STAGES-2:0], d};
      end
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Staggered multi-domain reset release with PLL lock filtering,
// lock-loss / software re-entry and last-cause recording.
module rst_sequencer
   import rst_seq_pkg::*;
#(
   parameter int N_DOMAINS      = 3,
   parameter int SYNC_STAGES    = 2,
   parameter int MIN_HOLD       = 4,
   parameter int LOCK_FILTER    = 16,
   parameter int STAGGER_CYCLES = 8
) (
   input  logic                 clk_riscv,
   input  logic                 rst_in,
   input  logic                 pll_locked,
   input  logic                 sw_rst_req,
   output logic [N_DOMAINS-1:0] domain_rst_n,
   output logic                 rst_done,
   output logic [1:0]           rst_cause,
   output logic                 lock_lost
);

   localparam int CW = width_of(max3(MIN_HOLD, LOCK_FILTER,
                                     STAGGER_CYCLES));
   localparam int IW = width_of(N_DOMAINS);

   localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_HOLD - 1);
   localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_FILTER - 1);
   localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(N_DOMAINS - 1);
   localparam logic [N_DOMAINS-1:0] DOM0 = N_DOMAINS'(1);

   state_t          state;
   cause_t          cause;
   logic [CW-1:0]   cnt;
   logic [IW-1:0]   idx;
   logic [IW-1:0]   idx_nxt;
   logic            req_q;
   logic            sw_edge;
   logic            ran_once;
   logic            rst_s;
   logic            lock_s;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_rst_sync (
      .clk_riscv (clk_riscv),
      .clr_n     (rst_in),
      .d         (1'b1),
      .q         (rst_s)
   );

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk_riscv (clk_riscv),
      .clr_n     (rst_in),
      .d         (pll_locked),
      .q         (lock_s)
   );

   assign idx_nxt   = idx + IW'(1);
   assign sw_edge   = sw_rst_req & ~req_q;
   assign rst_cause = cause;

   always_ff @(posedge clk_riscv or negedge rst_in) begin
      if (!rst_in) begin
         state        <= HOLD;
         cause        <= CAUSE_PIN;
         cnt          <= '0;
         idx          <= '0;
         req_q        <= 1'b0;
         ran_once     <= 1'b0;
         lock_lost    <= 1'b0;
         domain_rst_n <= '0;
         rst_done     <= 1'b0;
      end else begin
         req_q <= sw_rst_req;
         if (!rst_s) begin
            state <= HOLD;
            cnt   <= '0;
         end else begin
            // once the system has run, any lock drop is reported
            if (ran_once && !lock_s) begin
               lock_lost <= 1'b1;
            end
            unique case (state)
               HOLD: begin
                  domain_rst_n <= '0;
                  rst_done     <= 1'b0;
                  if (cnt == HOLD_LAST) begin
                     state <= WAIT_LOCK;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               WAIT_LOCK: begin
                  if (!lock_s) begin
                     cnt <= '0;
                  end else if (cnt == LOCK_LAST) begin
                     domain_rst_n <= DOM0;
                     cnt          <= '0;
                     idx          <= '0;
                     if (N_DOMAINS == 1) begin
                        state    <= RUN;
                        rst_done <= 1'b1;
                        ran_once <= 1'b1;
                     end else begin
                        state <= STAGGER;
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               STAGGER: begin
                  if (!lock_s) begin
                     state        <= HOLD;
                     cause        <= CAUSE_LOCK;
                     cnt          <= '0;
                     idx          <= '0;
                     domain_rst_n <= '0;
                     rst_done     <= 1'b0;
                  end else if (cnt == STAG_LAST) begin
                     cnt          <= '0;
                     idx          <= idx_nxt;
                     domain_rst_n <= domain_rst_n | (DOM0 << idx_nxt);
                     if (idx_nxt == IDX_LAST) begin
                        state    <= RUN;
                        rst_done <= 1'b1;
                        ran_once <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               RUN: begin
                  // lock loss outranks a simultaneous software request
                  if (!lock_s) begin
                     state        <= HOLD;
                     cause        <= CAUSE_LOCK;
                     cnt          <= '0;
                     idx          <= '0;
                     domain_rst_n <= '0;
                     rst_done     <= 1'b0;
                  end else if (sw_edge) begin
                     state        <= HOLD;
                     cause        <= CAUSE_SW;
                     cnt          <= '0;
                     idx          <= '0;
                     domain_rst_n <= '0;
                     rst_done     <= 1'b0;
                  end
               end
               default: begin
                  state <= HOLD;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: expected output changes are
// queued with their edge number; a negedge monitor pops and compares.
module tb_rst_sequencer;

   typedef struct {
      int         c;
      logic [2:0] dom;
      logic       done;
      logic [1:0] cause;
      logic       lost;
   } exp_t;

   logic       clk_riscv;
   logic       rst_in;
   logic       pll_locked;
   logic       sw_rst_req;
   logic [2:0] domain_rst_n;
   logic       rst_done;
   logic [1:0] rst_cause;
   logic       lock_lost;

   logic [0:0] one_dom;
   logic       one_done;
   logic [1:0] one_cause;
   logic       one_lost;

   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t q[$];
   exp_t e;
   logic [6:0] cur;
   logic [6:0] prev = 7'd0;
   logic [6:0] want;

   rst_sequencer u_dut (
      .clk_riscv    (clk_riscv),
      .rst_in       (rst_in),
      .pll_locked   (pll_locked),
      .sw_rst_req   (sw_rst_req),
      .domain_rst_n (domain_rst_n),
      .rst_done     (rst_done),
      .rst_cause    (rst_cause),
      .lock_lost    (lock_lost)
   );

   rst_sequencer #(
      .N_DOMAINS      (1),
      .STAGGER_CYCLES (1)
   ) u_one (
      .clk_riscv    (clk_riscv),
      .rst_in       (rst_in),
      .pll_locked   (pll_locked),
      .sw_rst_req   (1'b0),
      .domain_rst_n (one_dom),
      .rst_done     (one_done),
      .rst_cause    (one_cause),
      .lock_lost    (one_lost)
   );

   initial begin
      clk_riscv = 1'b0;
      forever #5 clk_riscv = ~clk_riscv;
   end

   always @(posedge clk_riscv) cyc = cyc + 1;

   always @(negedge clk_riscv) begin
      cur = {domain_rst_n, rst_done, rst_cause, lock_lost};
      if (cur !== prev) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_change cyc=%0d got=%b", cyc, cur);
         end else begin
            e    = q.pop_front();
            want = {e.dom, e.done, e.cause, e.lost};
            if (want !== cur || e.c != cyc) begin
               n_err++;
               $display("FAIL out_change got=%b@%0d want=%b@%0d",
                        cur, cyc, want, e.c);
            end
         end
         prev = cur;
      end
   end

   task automatic push(input int c, input logic [2:0] d,
                       input logic dn, input logic [1:0] ca,
                       input logic lo);
      exp_t x;
      x.c     = c;
      x.dom   = d;
      x.done  = dn;
      x.cause = ca;
      x.lost  = lo;
      q.push_back(x);
   endtask

   task automatic check(input string nm, input logic [7:0] got,
                        input logic [7:0] exp_v);
      n_cmp++;
      if (got !== exp_v) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h", nm, got, exp_v);
      end
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) begin
         @(posedge clk_riscv);
         #1;
      end
   endtask

   initial begin
      rst_in     = 1'b1;
      pll_locked = 1'b1;
      sw_rst_req = 1'b0;
      #2 rst_in  = 1'b0;

      // power-up: rst_s rises at edge 5, so cycle 0 = edge 5
      wait_cyc(3);
      check("reset_state",
            {1'b0, domain_rst_n, rst_done, rst_cause, lock_lost},
            8'h00);
      push(25, 3'b001, 1'b0, 2'd0, 1'b0);
      push(33, 3'b011, 1'b0, 2'd0, 1'b0);
      push(41, 3'b111, 1'b1, 2'd0, 1'b0);
      rst_in = 1'b1;
      wait_cyc(24);
      check("one_dom_pre", {6'd0, one_dom, one_done}, 8'h00);
      wait_cyc(25);
      check("one_dom_rel", {6'd0, one_dom, one_done}, 8'h03);
      check("one_cause", {5'd0, one_cause, one_lost}, 8'h00);

      // lock drop in RUN
      push(48, 3'b000, 1'b0, 2'd1, 1'b1);
      push(78, 3'b001, 1'b0, 2'd1, 1'b1);
      push(86, 3'b011, 1'b0, 2'd1, 1'b1);
      push(94, 3'b111, 1'b1, 2'd1, 1'b1);
      wait_cyc(45);
      pll_locked = 1'b0;
      wait_cyc(60);
      pll_locked = 1'b1;

      // software request held 50 cycles
      push(101, 3'b000, 1'b0, 2'd2, 1'b1);
      push(121, 3'b001, 1'b0, 2'd2, 1'b1);
      push(129, 3'b011, 1'b0, 2'd2, 1'b1);
      push(137, 3'b111, 1'b1, 2'd2, 1'b1);
      wait_cyc(100);
      sw_rst_req = 1'b1;
      wait_cyc(150);
      sw_rst_req = 1'b0;

      // one-cycle lock_s glitch at filter count 10
      push(161, 3'b000, 1'b0, 2'd2, 1'b1);
      push(192, 3'b001, 1'b0, 2'd2, 1'b1);
      push(200, 3'b011, 1'b0, 2'd2, 1'b1);
      push(208, 3'b111, 1'b1, 2'd2, 1'b1);
      wait_cyc(160);
      sw_rst_req = 1'b1;
      wait_cyc(170);
      sw_rst_req = 1'b0;
      wait_cyc(173);
      pll_locked = 1'b0;
      wait_cyc(174);
      pll_locked = 1'b1;

      // rst_in pulse mid-STAGGER
      push(221, 3'b000, 1'b0, 2'd2, 1'b1);
      push(241, 3'b001, 1'b0, 2'd2, 1'b1);
      push(245, 3'b000, 1'b0, 2'd0, 1'b0);
      push(269, 3'b001, 1'b0, 2'd0, 1'b0);
      push(277, 3'b011, 1'b0, 2'd0, 1'b0);
      push(285, 3'b111, 1'b1, 2'd0, 1'b0);
      wait_cyc(220);
      sw_rst_req = 1'b1;
      wait_cyc(230);
      sw_rst_req = 1'b0;
      wait_cyc(245);
      #1 rst_in = 1'b0;
      #1;
      check("async_clear",
            {1'b0, domain_rst_n, rst_done, rst_cause, lock_lost},
            8'h00);
      wait_cyc(247);
      rst_in = 1'b1;

      wait_cyc(300);
      check("queue_drained", 8'(q.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
